// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller
//   Turns the byte stream from a UART receiver into register-write commands.
//   A frame is SYNC(0xA5), ADDR, DATA, CHK with CHK = (ADDR + DATA) mod 256.
//   Each good frame with ADDR < NUM_REGS gives one write strobe. Bad or
//   out-of-range frames are dropped and counted.
//
// Ports
//   CLK_i        in   1       system clock, rising edge
//   Reset_i      in   1       asynchronous reset, active-high
//   rx_valid_i   in   1       one-cycle byte strobe
//   rx_data_i    in   8       received byte, valid with rx_valid_i
//   reg_we_o     out  1       one-cycle write strobe, 1 clock after the CHK byte
//   reg_addr_o   out  ADDR_W  write address, held until the next commit
//   reg_data_o   out  8       write data, held until the next commit
//   frame_err_o  out  1       one-cycle strobe per dropped frame
//   err_count_o  out  8       dropped-frame count, saturates at 255
//   busy_o       out  1       high whenever the FSM is not in WAIT_SYNC
//
// Build option
//   FRAME_TIMEOUT_EN  when defined, a partial frame is dropped after
//                     TIMEOUT_BYTES byte times of silence. When undefined,
//                     a partial frame waits indefinitely.
module uart_cmd_controller #(
  parameter logic [31:0] FREQUENCY     = 32'd50_000_000,
  parameter logic [31:0] SPEED         = 32'd9600,
  parameter int          NUM_REGS      = 16,
  parameter int          ADDR_W        = 4,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic              CLK_i,
  input  logic              Reset_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_data_o,
  output logic              frame_err_o,
  output logic [7:0]        err_count_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    COMMIT
  } state_e;

  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam logic [31:0] NUM_REGS_U   = NUM_REGS;
  localparam logic [31:0] TIMEOUT_CLKS = 32'(TIMEOUT_BYTES) * 32'd10 * (FREQUENCY / SPEED);

  state_e            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              busy_q, busy_d;
  logic              drop;
  logic [7:0]        chk_sum;
  logic              frame_ok;

  // Carry is discarded; the address check uses the full 8-bit ADDR byte.
  assign chk_sum  = addr_q + data_q;
  assign frame_ok = (chk_sum == rx_data_i) && ({24'd0, addr_q} < NUM_REGS_U);

`ifdef FRAME_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        in_frame;

  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CHK);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLKS;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    drop       = 1'b0;

    case (state_q)
      // COMMIT lasts one cycle; a byte arriving then is treated as in WAIT_SYNC.
      WAIT_SYNC, COMMIT: begin
        state_d = (rx_valid_i && (rx_data_i == SYNC_BYTE)) ? GET_ADDR : WAIT_SYNC;
      end
      GET_ADDR: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i;
          state_d = GET_DATA;
        end
      end
      GET_DATA: begin
        if (rx_valid_i) begin
          data_d  = rx_data_i;
          state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (rx_valid_i) begin
          if (frame_ok) begin
            state_d    = COMMIT;
            reg_we_d   = 1'b1;
            reg_addr_d = addr_q[ADDR_W-1:0];
            reg_data_d = data_q;
          end else begin
            drop    = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

`ifdef FRAME_TIMEOUT_EN
    // timer_q counts clocks since the last byte strobe (1 in the cycle right
    // after it), so a drop decided at TIMEOUT_CLKS-1 shows on frame_err_o
    // exactly TIMEOUT_CLKS clocks after the strobe. A byte in the expiry
    // cycle wins over the timeout.
    if (in_frame && !rx_valid_i && (timer_q == TIMEOUT_CLKS - 32'd1)) begin
      drop    = 1'b1;
      state_d = WAIT_SYNC;
    end
    if ((state_d == GET_ADDR) || (state_d == GET_DATA) || (state_d == GET_CHK)) begin
      timer_d = rx_valid_i ? 32'd1 : timer_q + 32'd1;
    end else begin
      timer_d = 32'd0;
    end
`endif

    frame_err_d = drop;
    err_count_d = (drop && (err_count_q != 8'd255)) ? err_count_q + 8'd1 : err_count_q;
    busy_d      = (state_d != WAIT_SYNC);
  end

  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= WAIT_SYNC;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= 8'd0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
      busy_q      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      timer_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
`ifdef FRAME_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign reg_we_o    = reg_we_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_data_o  = reg_data_q;
  assign frame_err_o = frame_err_q;
  assign err_count_o = err_count_q;
  assign busy_o      = busy_q;

endmodule
